dfd_xtrigger_in_qualifier: RTL and testbench
============================================

Name: dfd_xtrigger_in_qualifier

Overview:
- Receive side of the CLA cross-trigger path. Consumes the stretched xtrigger levels driven by a remote stretch stage.
- Synchronizes each lane, rejects glitches shorter than a programmable minimum width, and emits exactly one single-cycle event per accepted trigger into the local CLA event logic.
- Keeps per-lane sticky status and saturating occurrence counters for CSR readback.

Parameters:
- XTRIGGER_WIDTH, 2, number of independent trigger lanes.
- MIN_HIGH_WIDTH, 4, width of the per-lane min-high threshold field.
- EVT_CNTR_WIDTH, 16, width of the per-lane occurrence counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- xtrigger_in  in  XTRIGGER_WIDTH  raw stretched trigger levels from the remote stretch stage.
- lane_en  in  XTRIGGER_WIDTH  per-lane qualify enable (CSR).
- min_high  in  XTRIGGER_WIDTH*MIN_HIGH_WIDTH  per-lane minimum consecutive high samples (CSR); 0 is treated as 1.
- status_clr  in  XTRIGGER_WIDTH  per-lane clear for sticky status and counter (CSR write pulse).
- xtrigger_evt  out  XTRIGGER_WIDTH  one-cycle qualified event per accepted trigger.
- xtrigger_sticky  out  XTRIGGER_WIDTH  sticky "trigger seen".
- xtrigger_cnt  out  XTRIGGER_WIDTH*EVT_CNTR_WIDTH  saturating per-lane accepted-trigger count.
- xtrigger_stuck  out  XTRIGGER_WIDTH  stuck-high error flag; exists only when the optional feature is compiled in.

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchronizer flops 0.
  - FSM in IDLE.
  - Qualify counter 0.
  - Applies synchronously on any clock edge, including mid-qualification or mid-ACTIVE.
  - No event is emitted on reset exit, even if the input is already high; the lane must first sample low.
- Synchronizer: 2-flop per lane; sync_q = xtrigger_in delayed by 2 clocks.
- Per-lane FSM: IDLE, QUAL, ACTIVE, WAIT_LOW. Let N = max(min_high, 1).
  - IDLE:
    - sync_q=1 and lane_en=1 -> QUAL with qual_cnt=1.
    - If N==1, go directly to ACTIVE instead.
  - QUAL:
    - sync_q=1: qual_cnt++; when qual_cnt+1 == N -> ACTIVE.
    - sync_q=0 -> IDLE; glitch rejected, no event, no count.
    - lane_en=0 -> IDLE.
  - ACTIVE (entry cycle only): xtrigger_evt is registered high for the one cycle following entry; then the FSM moves to WAIT_LOW.
  - WAIT_LOW:
    - Stay while sync_q=1.
    - sync_q=0 -> IDLE.
    - The next event requires a new low-to-high transition.
- Latency: rising edge of xtrigger_in sampled at edge 0 -> xtrigger_evt high during cycle 2+N. Exactly one cycle wide regardless of how long the input stays high.
- min_high is sampled continuously. A change while in QUAL takes effect immediately; if qual_cnt >= new N, the FSM moves to ACTIVE on the next edge.
- lane_en=0: the FSM is held in IDLE and xtrigger_evt is 0. Deasserting lane_en in ACTIVE still lets the already-registered event complete.
- Sticky status: set on the cycle xtrigger_evt is asserted.
- Counter:
  - Increments when xtrigger_evt is asserted.
  - Saturates at 2^EVT_CNTR_WIDTH-1; no wrap.
- status_clr: clears sticky and counter.
  - If status_clr coincides with a new event, the set/increment wins: sticky=1, cnt=1.
- Lanes are fully independent; simultaneous events on multiple lanes are all reported in the same cycle.

Optional Feature:
- Macro: DFD_XTRIGGER_QUAL_STUCK_DETECT_EN.
- With macro:
  - Adds a per-lane 8-bit counter that counts cycles in WAIT_LOW.
  - When it reaches 255, xtrigger_stuck[i] is set (sticky) and the counter holds.
  - The FSM stays in WAIT_LOW until sync_q=0.
  - Cleared by status_clr or reset.
  - The counter resets on entry to WAIT_LOW.
- Without macro: the xtrigger_stuck port and counters are absent.

Test Plan:
- min_high=0, lane 0: 3-cycle high pulse on xtrigger_in at cycle 10 -> xtrigger_evt[0] high only at cycle 13; sticky=1; cnt=1.
- min_high=4: 3-cycle glitch -> no event, cnt unchanged. Then 4-cycle pulse -> event at rise+6; cnt=1.
- Input held high 100 cycles, then a low gap of 2 cycles, then high again -> exactly 2 events, cnt=2.
- Lanes 0 and 1 rise in the same cycle with min_high=1 -> both xtrigger_evt bits high in the same cycle. status_clr[0] coincident with a lane-0 event -> cnt[0]=1, sticky[0]=1.
- Counter preloaded to 0xFFFE (via 0xFFFE pulses, or a forced start) plus 3 events -> cnt=0xFFFF, no wrap.
- Reset asserted during QUAL with input held high -> outputs 0; after reset release with input still high, no event until low then high. With DFD_XTRIGGER_QUAL_STUCK_DETECT_EN: input high 300 cycles -> xtrigger_stuck set at cycle 255 of WAIT_LOW.

Source files
------------

// File: rtl/dfd_xtrigger_in_qualifier.sv
// Cross-trigger receive qualifier: per-lane sync, min-width glitch filter, one-shot event, sticky + saturating count.
// Optional stuck-high detection under `DFD_XTRIGGER_QUAL_STUCK_DETECT_EN`.
//
// state      | meaning
// S_IDLE     | waiting for a qualified rising level (lane enabled, low seen since reset)
// S_QUAL     | counting consecutive high samples up to N = max(min_high,1)
// S_ACTIVE   | accepted; event registered on the edge leaving this state
// S_WAIT_LOW | trigger consumed, waiting for the level to drop before re-arming
module dfd_xtrigger_in_qualifier #(
  parameter int XTRIGGER_WIDTH = 2,
  parameter int MIN_HIGH_WIDTH = 4,
  parameter int EVT_CNTR_WIDTH = 16
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic [XTRIGGER_WIDTH-1:0]                  i_xtrigger_in,
  input  logic [XTRIGGER_WIDTH-1:0]                  i_lane_en,
  input  logic [XTRIGGER_WIDTH*MIN_HIGH_WIDTH-1:0]   i_min_high,
  input  logic [XTRIGGER_WIDTH-1:0]                  i_status_clr,
  output logic [XTRIGGER_WIDTH-1:0]                  o_xtrigger_evt,
  output logic [XTRIGGER_WIDTH-1:0]                  o_xtrigger_sticky,
  output logic [XTRIGGER_WIDTH*EVT_CNTR_WIDTH-1:0]   o_xtrigger_cnt
`ifdef DFD_XTRIGGER_QUAL_STUCK_DETECT_EN
  ,
  output logic [XTRIGGER_WIDTH-1:0]                  o_xtrigger_stuck
`endif
);

  localparam int QW = MIN_HIGH_WIDTH;
  localparam int CW = EVT_CNTR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_QUAL     = 2'd1,
    S_ACTIVE   = 2'd2,
    S_WAIT_LOW = 2'd3
  } state_t;

  logic [XTRIGGER_WIDTH-1:0] r_sync1;
  logic [XTRIGGER_WIDTH-1:0] r_sync_q;
  logic [1:0]                r_vld;
  logic [XTRIGGER_WIDTH-1:0] r_armed;
  state_t                    r_state        [XTRIGGER_WIDTH];
  state_t                    w_state_nxt    [XTRIGGER_WIDTH];
  logic [QW-1:0]             r_qual_cnt     [XTRIGGER_WIDTH];
  logic [QW-1:0]             w_qual_cnt_nxt [XTRIGGER_WIDTH];
  logic [XTRIGGER_WIDTH-1:0] w_fire;
  logic [XTRIGGER_WIDTH-1:0] r_evt;
  logic [XTRIGGER_WIDTH-1:0] r_sticky;
  logic [CW-1:0]             r_cnt          [XTRIGGER_WIDTH];

  // r_vld tracks when sync_q holds real input samples, so the post-reset zeros
  // in the synchronizer are never mistaken for a genuine low level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1  <= '0;
      r_sync_q <= '0;
      r_vld    <= '0;
      r_armed  <= '0;
    end else begin
      r_sync1  <= i_xtrigger_in;
      r_sync_q <= r_sync1;
      r_vld    <= {r_vld[0], 1'b1};
      r_armed  <= r_armed | ({XTRIGGER_WIDTH{r_vld[1]}} & ~r_sync_q);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < XTRIGGER_WIDTH; i++) begin
        r_state[i]    <= S_IDLE;
        r_qual_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < XTRIGGER_WIDTH; i++) begin
        r_state[i]    <= w_state_nxt[i];
        r_qual_cnt[i] <= w_qual_cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < XTRIGGER_WIDTH; i++) begin
      logic [QW:0] n_req;
      n_req = {1'b0, i_min_high[i*QW +: QW]};
      if (n_req == '0) n_req = (QW+1)'(1);
      w_state_nxt[i]    = r_state[i];
      w_qual_cnt_nxt[i] = r_qual_cnt[i];
      case (r_state[i])
        S_IDLE: begin
          if (r_sync_q[i] && i_lane_en[i] && r_armed[i]) begin
            w_qual_cnt_nxt[i] = QW'(1);
            w_state_nxt[i]    = (n_req == (QW+1)'(1)) ? S_ACTIVE : S_QUAL;
          end
        end
        S_QUAL: begin
          if (!r_sync_q[i] || !i_lane_en[i]) begin
            w_state_nxt[i]    = S_IDLE;
            w_qual_cnt_nxt[i] = '0;
          end else if (({1'b0, r_qual_cnt[i]} + 1'b1) >= n_req) begin
            // >= so a lowered min_high mid-qualification takes effect at once
            w_state_nxt[i] = S_ACTIVE;
          end else begin
            w_qual_cnt_nxt[i] = r_qual_cnt[i] + 1'b1;
          end
        end
        S_ACTIVE: begin
          w_state_nxt[i]    = S_WAIT_LOW;
          w_qual_cnt_nxt[i] = '0;
        end
        S_WAIT_LOW: begin
          if (!r_sync_q[i] || !i_lane_en[i]) w_state_nxt[i] = S_IDLE;
        end
        default: begin
          w_state_nxt[i]    = S_IDLE;
          w_qual_cnt_nxt[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_fire = '0;
    for (int i = 0; i < XTRIGGER_WIDTH; i++) begin
      w_fire[i] = (r_state[i] == S_ACTIVE);
    end
  end

  // Set/increment takes priority over a coincident clear.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_evt    <= '0;
      r_sticky <= '0;
      for (int i = 0; i < XTRIGGER_WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_evt <= w_fire;
      for (int i = 0; i < XTRIGGER_WIDTH; i++) begin
        if (w_fire[i]) begin
          r_sticky[i] <= 1'b1;
          if (i_status_clr[i])       r_cnt[i] <= CW'(1);
          else if (r_cnt[i] != '1)   r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (i_status_clr[i]) begin
          r_sticky[i] <= 1'b0;
          r_cnt[i]    <= '0;
        end
      end
    end
  end

`ifdef DFD_XTRIGGER_QUAL_STUCK_DETECT_EN
  logic [7:0]                r_stuck_cnt [XTRIGGER_WIDTH];
  logic [XTRIGGER_WIDTH-1:0] r_stuck;

  // WAIT_LOW is only entered from ACTIVE, so ACTIVE is where the count restarts.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stuck <= '0;
      for (int i = 0; i < XTRIGGER_WIDTH; i++) r_stuck_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < XTRIGGER_WIDTH; i++) begin
        if (r_state[i] == S_ACTIVE) begin
          r_stuck_cnt[i] <= '0;
        end else if ((r_state[i] == S_WAIT_LOW) && (r_stuck_cnt[i] != 8'hFF)) begin
          r_stuck_cnt[i] <= r_stuck_cnt[i] + 1'b1;
        end
        if ((r_state[i] == S_WAIT_LOW) && (r_stuck_cnt[i] == 8'hFE)) r_stuck[i] <= 1'b1;
        else if (i_status_clr[i])                                   r_stuck[i] <= 1'b0;
      end
    end
  end

  assign o_xtrigger_stuck = r_stuck;
`endif

  assign o_xtrigger_evt    = r_evt;
  assign o_xtrigger_sticky = r_sticky;

  always_comb begin
    o_xtrigger_cnt = '0;
    for (int i = 0; i < XTRIGGER_WIDTH; i++) begin
      o_xtrigger_cnt[i*CW +: CW] = r_cnt[i];
    end
  end

endmodule

// File: tb/tb_dfd_xtrigger_in_qualifier.sv
// Directed bench for dfd_xtrigger_in_qualifier; a second narrow-counter instance exercises saturation.
// Stuck-high checks are compiled only with DFD_XTRIGGER_QUAL_STUCK_DETECT_EN.
module tb_dfd_xtrigger_in_qualifier;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  x_in;
  logic [1:0]  en;
  logic [7:0]  min_high;
  logic [1:0]  clr;
  logic [1:0]  evt;
  logic [1:0]  sticky;
  logic [31:0] cnt;

  logic        s_in;
  logic        s_en;
  logic [3:0]  s_min;
  logic        s_clr;
  logic        s_evt;
  logic        s_sticky;
  logic [3:0]  s_cnt;

`ifdef DFD_XTRIGGER_QUAL_STUCK_DETECT_EN
  logic [1:0]  stuck;
  logic        s_stuck;
`endif

  int total = 0;
  int bad   = 0;
  int ev0, ev1, ev_s, first0, first1, tcount;

  always #5 clk = ~clk;

  dfd_xtrigger_in_qualifier #(
    .XTRIGGER_WIDTH(2), .MIN_HIGH_WIDTH(4), .EVT_CNTR_WIDTH(16)
  ) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_xtrigger_in     (x_in),
    .i_lane_en         (en),
    .i_min_high        (min_high),
    .i_status_clr      (clr),
    .o_xtrigger_evt    (evt),
    .o_xtrigger_sticky (sticky),
    .o_xtrigger_cnt    (cnt)
`ifdef DFD_XTRIGGER_QUAL_STUCK_DETECT_EN
    ,
    .o_xtrigger_stuck  (stuck)
`endif
  );

  dfd_xtrigger_in_qualifier #(
    .XTRIGGER_WIDTH(1), .MIN_HIGH_WIDTH(4), .EVT_CNTR_WIDTH(4)
  ) dut_sat (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_xtrigger_in     (s_in),
    .i_lane_en         (s_en),
    .i_min_high        (s_min),
    .i_status_clr      (s_clr),
    .o_xtrigger_evt    (s_evt),
    .o_xtrigger_sticky (s_sticky),
    .o_xtrigger_cnt    (s_cnt)
`ifdef DFD_XTRIGGER_QUAL_STUCK_DETECT_EN
    ,
    .o_xtrigger_stuck  (s_stuck)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_obs();
    ev0 = 0; ev1 = 0; ev_s = 0; first0 = -1; first1 = -1; tcount = 0;
  endtask

  // tcount is the index of the cycle that begins at the edge just taken;
  // cycle 0 is the first edge that samples the newly driven level.
  task automatic drive(input logic [1:0] x, input int n);
    x_in = x;
    repeat (n) begin
      @(posedge clk); #1;
      if (evt[0]) begin ev0++; if (first0 < 0) first0 = tcount; end
      if (evt[1]) begin ev1++; if (first1 < 0) first1 = tcount; end
      if (s_evt) ev_s++;
      tcount++;
    end
  endtask

  initial begin
    rst = 1'b1; x_in = 2'b00; en = 2'b11; min_high = 8'h00; clr = 2'b00;
    s_in = 1'b0; s_en = 1'b1; s_min = 4'd0; s_clr = 1'b0;
    reset_obs();
    drive(2'b00, 3);
    check("reset_evt",    {30'd0, evt},    32'd0);
    check("reset_sticky", {30'd0, sticky}, 32'd0);
    check("reset_cnt",    cnt,             32'd0);
    check("reset_s_cnt",  {28'd0, s_cnt},  32'd0);
    rst = 1'b0;
    drive(2'b00, 5);

    // min_high=0 behaves as 1: 3-cycle pulse gives one event at rise+3
    min_high = 8'h00;
    reset_obs(); drive(2'b01, 3); drive(2'b00, 10);
    check("t1_first0", first0, 32'd3);
    check("t1_ev0",    ev0,    32'd1);
    check("t1_ev1",    ev1,    32'd0);
    check("t1_sticky", {30'd0, sticky}, 32'd1);
    check("t1_cnt",    cnt,    32'h0000_0001);

    clr = 2'b01; drive(2'b00, 1); clr = 2'b00;
    check("clr_sticky", {30'd0, sticky}, 32'd0);
    check("clr_cnt",    cnt,             32'd0);

    // min_high=4: 3-cycle glitch rejected, 4-cycle pulse accepted at rise+6
    min_high = {4'd0, 4'd4};
    reset_obs(); drive(2'b01, 3); drive(2'b00, 10);
    check("t2_glitch_ev0", ev0, 32'd0);
    check("t2_glitch_cnt", cnt, 32'd0);
    reset_obs(); drive(2'b01, 4); drive(2'b00, 10);
    check("t2_first0", first0, 32'd6);
    check("t2_ev0",    ev0,    32'd1);
    check("t2_cnt",    cnt,    32'h0000_0001);

    // long high, 2-cycle gap, high again: exactly two events
    min_high = {4'd1, 4'd1};
    reset_obs(); drive(2'b01, 100); drive(2'b00, 2); drive(2'b01, 10); drive(2'b00, 10);
    check("t3_ev0",    ev0,    32'd2);
    check("t3_first0", first0, 32'd3);
    check("t3_cnt",    cnt,    32'h0000_0003);

    // both lanes rise together
    reset_obs(); drive(2'b11, 3); drive(2'b00, 10);
    check("t4_first0", first0, 32'd3);
    check("t4_first1", first1, 32'd3);
    check("t4_ev0",    ev0,    32'd1);
    check("t4_ev1",    ev1,    32'd1);
    check("t4_cnt",    cnt,    32'h0001_0004);

    // clear sampled on the same edge that registers a lane-0 event
    reset_obs(); drive(2'b01, 3);
    clr = 2'b01; drive(2'b01, 1); clr = 2'b00;
    check("t4c_evt", {30'd0, evt}, 32'd1);
    drive(2'b00, 8);
    check("t4c_ev0",    ev0,             32'd1);
    check("t4c_cnt",    cnt,             32'h0001_0001);
    check("t4c_sticky", {30'd0, sticky}, 32'd3);

    // lane disabled: no event
    en = 2'b10;
    reset_obs(); drive(2'b01, 6); drive(2'b00, 6);
    check("t5_en_ev0", ev0, 32'd0);
    en = 2'b11;

    // lowering min_high mid-qualification accepts a pulse shorter than the old N
    min_high = {4'd1, 4'd8};
    reset_obs(); drive(2'b01, 5);
    min_high = {4'd1, 4'd2};
    drive(2'b00, 10);
    check("t6_first0", first0, 32'd6);
    check("t6_ev0",    ev0,    32'd1);

    // reset during QUAL with input held high; no event until low-then-high
    min_high = {4'd1, 4'd4};
    reset_obs(); drive(2'b01, 4);
    rst = 1'b1; drive(2'b01, 1);
    check("t7_rst_evt",    {30'd0, evt},    32'd0);
    check("t7_rst_sticky", {30'd0, sticky}, 32'd0);
    check("t7_rst_cnt",    cnt,             32'd0);
    rst = 1'b0;
    drive(2'b01, 15);
    check("t7_held_ev0", ev0, 32'd0);
    drive(2'b00, 3);
    reset_obs(); drive(2'b01, 4); drive(2'b00, 8);
    check("t7_first0", first0, 32'd6);
    check("t7_ev0",    ev0,    32'd1);
    check("t7_cnt",    cnt,    32'h0000_0001);

    // 4-bit counter: 14 events reach 0xE, 3 more saturate at 0xF
    drive(2'b00, 4);
    reset_obs();
    for (int k = 0; k < 14; k++) begin
      s_in = 1'b1; drive(2'b00, 2);
      s_in = 1'b0; drive(2'b00, 2);
    end
    drive(2'b00, 4);
    check("t8_pre_ev",  ev_s,            32'd14);
    check("t8_pre_cnt", {28'd0, s_cnt},  32'hE);
    for (int k = 0; k < 3; k++) begin
      s_in = 1'b1; drive(2'b00, 2);
      s_in = 1'b0; drive(2'b00, 2);
    end
    drive(2'b00, 4);
    check("t8_ev",     ev_s,            32'd17);
    check("t8_cnt",    {28'd0, s_cnt},  32'hF);
    check("t8_sticky", {31'd0, s_sticky}, 32'd1);

`ifdef DFD_XTRIGGER_QUAL_STUCK_DETECT_EN
    // WAIT_LOW starts in cycle 3; stuck appears once its counter reaches 255 (cycle 258)
    min_high = {4'd1, 4'd1};
    reset_obs(); drive(2'b01, 258);
    check("t9_stuck_before", {30'd0, stuck}, 32'd0);
    drive(2'b01, 1);
    check("t9_stuck_set",    {30'd0, stuck}, 32'd1);
    drive(2'b00, 5);
    check("t9_stuck_hold",   {30'd0, stuck}, 32'd1);
    check("t9_ev0",          ev0,            32'd1);
    clr = 2'b01; drive(2'b00, 1); clr = 2'b00;
    check("t9_stuck_clr",    {30'd0, stuck}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
